i_decode: RTL and testbench
===========================

# i_decode

Instruction decode stage of the five-stage MIPS pipeline, directly downstream of the fetch stage: consumes the IF/ID instruction and next-PC, reads a 32x32 register file, decodes the opcode into control bundles, sign-extends the immediate, and registers everything into the ID/EX latch. Writeback from the MEM/WB stage also lands here, in the register file.

## Interface
- No parameters; widths fixed at 32-bit data, 5-bit register index.
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- IF_ID_instr  input  32  instruction from IF/ID latch.
- IF_ID_npc  input  32  PC+4 from IF/ID latch.
- MEM_WB_RegWrite  input  1  writeback enable.
- MEM_WB_writereg  input  5  writeback destination register.
- MEM_WB_writedata  input  32  writeback data.
- flush  input  1  squash: zero control bundles entering ID/EX this cycle (driven by EX_MEM_PCSrc).
- ID_EX_wb_ctl  output  2  {RegWrite, MemtoReg}.
- ID_EX_m_ctl  output  3  {Branch, MemRead, MemWrite}.
- ID_EX_regdst  output  1  destination select (1 = rd).
- ID_EX_alusrc  output  1  ALU B select (1 = immediate).
- ID_EX_aluop  output  2  ALU op class.
- ID_EX_npc  output  32  registered IF_ID_npc.
- ID_EX_readdat1  output  32  rs value.
- ID_EX_readdat2  output  32  rt value.
- ID_EX_sign_ext  output  32  sign-extended instr[15:0].
- ID_EX_instr_2016  output  5  instr[20:16] (rt).
- ID_EX_instr_1511  output  5  instr[15:11] (rd).

## Operation
- Register file: 32 entries x 32 bits. Write on rising clk when MEM_WB_RegWrite=1 and MEM_WB_writereg!=0. Register 0 always reads 0; writes to it ignored.
- Read ports: combinational on instr[25:21] (rs) and instr[20:16] (rt). Write-through bypass: if a read index equals MEM_WB_writereg, nonzero, with RegWrite=1 in the same cycle, the read returns MEM_WB_writedata (write-before-read).
- Control decode on instr[31:26]:
  - 0x00 R-type: regdst=1, aluop=10, alusrc=0, m=000, wb=10.
  - 0x23 lw: regdst=0, aluop=00, alusrc=1, m=010, wb=11.
  - 0x2B sw: regdst=0, aluop=00, alusrc=1, m=001, wb=00.
  - 0x04 beq: regdst=0, aluop=01, alusrc=0, m=100, wb=00.
  - Any other opcode: all control fields 0 (bubble); data fields still latched.
- Sign extension: {{16{instr[15]}}, instr[15:0]}.
- ID/EX latch: every rising clk, all outputs load their decode-side values. When flush=1, wb, m, regdst, alusrc, aluop load 0; data fields (npc, readdat, sign_ext, indices) load normally.

## Timing
- Reset (rst=1 at rising edge): all ID/EX outputs 0; all 32 registers 0. Reset dominates flush and writeback in the same cycle.
- Decode latency: 1 cycle; instruction present on IF_ID_instr before edge N appears decoded on ID/EX outputs after edge N.
- Writeback: data written at edge N is visible to reads in the cycle of edge N via bypass, and from the register array thereafter.
- Reset deasserted mid-stream: first edge after deassertion latches the current IF_ID inputs normally.
- flush and a valid opcode in the same cycle: flush wins for control; no register file effect (flush never gates writeback).
- No stall input; the latch loads every cycle.

## Test plan
- Reset: hold rst for 2 cycles with IF_ID_instr=0x8C220004 -> all ID/EX outputs 0; read of any register returns 0.
- Writeback then lw: write r2=0x0000_00AA (RegWrite=1, writereg=2), next cycle IF_ID_instr=0x8C430010 (lw r3,16(r2)) -> readdat1=0xAA, sign_ext=0x10, instr_2016=3, wb=11, m=010, alusrc=1, aluop=00.
- Bypass + r0: same cycle write r5=0x1234_5678 and decode 0x00A53020 (add r6,r5,r5) -> readdat1=readdat2=0x12345678, regdst=1, instr_1511=6; separately write r0=0xFFFF_FFFF -> reading r0 returns 0.
- Sign extension / beq: IF_ID_instr=0x1000FFFC -> sign_ext=0xFFFFFFFC, m=100, aluop=01, wb=00; IF_ID_npc=0x0000_0040 -> ID_EX_npc=0x40.
- Flush and illegal opcode: sw 0xAC220000 with flush=1 -> all control 0, readdat/indices valid; opcode 0x3F without flush -> all control 0.
- Reset mid-operation: registers loaded, assert rst one cycle during lw -> outputs and registers 0 next cycle; next lw after deassertion reads 0 from prior-written register.

Source files
------------

// File: rtl/i_decode.sv
// MIPS instruction decode stage: register file with write-through bypass,
// opcode-to-control decode, immediate sign extension and the ID/EX latch.
module i_decode (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] IF_ID_instr,
  input  logic [31:0] IF_ID_npc,
  input  logic        MEM_WB_RegWrite,
  input  logic [4:0]  MEM_WB_writereg,
  input  logic [31:0] MEM_WB_writedata,
  input  logic        flush,
  output logic [1:0]  ID_EX_wb_ctl,
  output logic [2:0]  ID_EX_m_ctl,
  output logic        ID_EX_regdst,
  output logic        ID_EX_alusrc,
  output logic [1:0]  ID_EX_aluop,
  output logic [31:0] ID_EX_npc,
  output logic [31:0] ID_EX_readdat1,
  output logic [31:0] ID_EX_readdat2,
  output logic [31:0] ID_EX_sign_ext,
  output logic [4:0]  ID_EX_instr_2016,
  output logic [4:0]  ID_EX_instr_1511
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  logic [31:0] regs [32];

  logic [5:0]  opcode;
  logic [4:0]  rs_idx;
  logic [4:0]  rt_idx;
  logic [4:0]  rd_idx;
  logic [31:0] sign_ext;
  logic [31:0] rd_data1;
  logic [31:0] rd_data2;
  logic        wb_active;

  logic [1:0]  dec_wb;
  logic [2:0]  dec_m;
  logic        dec_regdst;
  logic        dec_alusrc;
  logic [1:0]  dec_aluop;

  assign opcode    = IF_ID_instr[31:26];
  assign rs_idx    = IF_ID_instr[25:21];
  assign rt_idx    = IF_ID_instr[20:16];
  assign rd_idx    = IF_ID_instr[15:11];
  assign sign_ext  = {{16{IF_ID_instr[15]}}, IF_ID_instr[15:0]};
  assign wb_active = MEM_WB_RegWrite && (MEM_WB_writereg != 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_active) begin
      regs[MEM_WB_writereg] <= MEM_WB_writedata;
    end
  end

  // Writeback landing this cycle is forwarded so the reader sees it without waiting a cycle.
  function automatic logic [31:0] read_port(input logic [4:0] idx, input logic [31:0] arr_val);
    if (idx == 5'd0)
      return '0;
    else if (wb_active && (idx == MEM_WB_writereg))
      return MEM_WB_writedata;
    else
      return arr_val;
  endfunction

  assign rd_data1 = read_port(rs_idx, regs[rs_idx]);
  assign rd_data2 = read_port(rt_idx, regs[rt_idx]);

  always_comb begin
    dec_wb     = 2'b00;
    dec_m      = 3'b000;
    dec_regdst = 1'b0;
    dec_alusrc = 1'b0;
    dec_aluop  = 2'b00;
    case (opcode)
      OP_RTYPE: begin
        dec_regdst = 1'b1;
        dec_aluop  = 2'b10;
        dec_wb     = 2'b10;
      end
      OP_LW: begin
        dec_alusrc = 1'b1;
        dec_m      = 3'b010;
        dec_wb     = 2'b11;
      end
      OP_SW: begin
        dec_alusrc = 1'b1;
        dec_m      = 3'b001;
      end
      OP_BEQ: begin
        dec_aluop  = 2'b01;
        dec_m      = 3'b100;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ID_EX_wb_ctl     <= '0;
      ID_EX_m_ctl      <= '0;
      ID_EX_regdst     <= 1'b0;
      ID_EX_alusrc     <= 1'b0;
      ID_EX_aluop      <= '0;
      ID_EX_npc        <= '0;
      ID_EX_readdat1   <= '0;
      ID_EX_readdat2   <= '0;
      ID_EX_sign_ext   <= '0;
      ID_EX_instr_2016 <= '0;
      ID_EX_instr_1511 <= '0;
    end else begin
      // Flush squashes only the control bundle; data still flows.
      ID_EX_wb_ctl     <= flush ? 2'b00 : dec_wb;
      ID_EX_m_ctl      <= flush ? 3'b000 : dec_m;
      ID_EX_regdst     <= flush ? 1'b0 : dec_regdst;
      ID_EX_alusrc     <= flush ? 1'b0 : dec_alusrc;
      ID_EX_aluop      <= flush ? 2'b00 : dec_aluop;
      ID_EX_npc        <= IF_ID_npc;
      ID_EX_readdat1   <= rd_data1;
      ID_EX_readdat2   <= rd_data2;
      ID_EX_sign_ext   <= sign_ext;
      ID_EX_instr_2016 <= rt_idx;
      ID_EX_instr_1511 <= rd_idx;
    end
  end

endmodule

// File: tb/tb_i_decode.sv
// Bench for i_decode: directed scenarios plus randomized traffic, all checked
// against a behavioural register-file/decode model.
module tb_i_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] IF_ID_instr;
  logic [31:0] IF_ID_npc;
  logic        MEM_WB_RegWrite;
  logic [4:0]  MEM_WB_writereg;
  logic [31:0] MEM_WB_writedata;
  logic        flush;
  logic [1:0]  ID_EX_wb_ctl;
  logic [2:0]  ID_EX_m_ctl;
  logic        ID_EX_regdst;
  logic        ID_EX_alusrc;
  logic [1:0]  ID_EX_aluop;
  logic [31:0] ID_EX_npc;
  logic [31:0] ID_EX_readdat1;
  logic [31:0] ID_EX_readdat2;
  logic [31:0] ID_EX_sign_ext;
  logic [4:0]  ID_EX_instr_2016;
  logic [4:0]  ID_EX_instr_1511;

  int checks = 0;
  int failures = 0;

  logic [31:0] model_regs [32];

  i_decode dut (
    .clk(clk), .rst(rst),
    .IF_ID_instr(IF_ID_instr), .IF_ID_npc(IF_ID_npc),
    .MEM_WB_RegWrite(MEM_WB_RegWrite), .MEM_WB_writereg(MEM_WB_writereg),
    .MEM_WB_writedata(MEM_WB_writedata), .flush(flush),
    .ID_EX_wb_ctl(ID_EX_wb_ctl), .ID_EX_m_ctl(ID_EX_m_ctl),
    .ID_EX_regdst(ID_EX_regdst), .ID_EX_alusrc(ID_EX_alusrc),
    .ID_EX_aluop(ID_EX_aluop), .ID_EX_npc(ID_EX_npc),
    .ID_EX_readdat1(ID_EX_readdat1), .ID_EX_readdat2(ID_EX_readdat2),
    .ID_EX_sign_ext(ID_EX_sign_ext), .ID_EX_instr_2016(ID_EX_instr_2016),
    .ID_EX_instr_1511(ID_EX_instr_1511)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Control word {wb[1:0], m[2:0], regdst, alusrc, aluop[1:0]} from the opcode table.
  function automatic logic [8:0] ctl_of(input logic [5:0] op);
    case (op)
      6'h00:   return {2'b10, 3'b000, 1'b1, 1'b0, 2'b10};
      6'h23:   return {2'b11, 3'b010, 1'b0, 1'b1, 2'b00};
      6'h2B:   return {2'b00, 3'b001, 1'b0, 1'b1, 2'b00};
      6'h04:   return {2'b00, 3'b100, 1'b0, 1'b0, 2'b01};
      default: return 9'd0;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] idx, input logic we,
                                             input logic [4:0] wr, input logic [31:0] wd);
    if (idx == 0) return 32'd0;
    if (we && wr == idx) return wd;
    return model_regs[idx];
  endfunction

  // Apply one cycle of inputs, clock it, then compare every ID/EX output to the model.
  task automatic cyc(input logic r, input logic [31:0] ins, input logic [31:0] npc,
                     input logic we, input logic [4:0] wr, input logic [31:0] wd,
                     input logic fl);
    logic [8:0]  e_ctl;
    logic [31:0] e_rd1, e_rd2, e_sx, e_npc;
    logic [4:0]  e_rt, e_rd;
    rst = r; IF_ID_instr = ins; IF_ID_npc = npc;
    MEM_WB_RegWrite = we; MEM_WB_writereg = wr; MEM_WB_writedata = wd; flush = fl;
    e_ctl = fl ? 9'd0 : ctl_of(ins[31:26]);
    e_rd1 = model_read(ins[25:21], we, wr, wd);
    e_rd2 = model_read(ins[20:16], we, wr, wd);
    e_sx  = $signed(ins[15:0]);
    e_npc = npc;
    e_rt  = ins[20:16];
    e_rd  = ins[15:11];
    if (r) begin
      e_ctl = 0; e_rd1 = 0; e_rd2 = 0; e_sx = 0; e_npc = 0; e_rt = 0; e_rd = 0;
    end
    @(posedge clk);
    #1;
    if (r) begin
      for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
    end else if (we && wr != 0) begin
      model_regs[wr] = wd;
    end
    chk("wb_ctl",  {30'd0, ID_EX_wb_ctl}, {30'd0, e_ctl[8:7]});
    chk("m_ctl",   {29'd0, ID_EX_m_ctl},  {29'd0, e_ctl[6:4]});
    chk("regdst",  {31'd0, ID_EX_regdst}, {31'd0, e_ctl[3]});
    chk("alusrc",  {31'd0, ID_EX_alusrc}, {31'd0, e_ctl[2]});
    chk("aluop",   {30'd0, ID_EX_aluop},  {30'd0, e_ctl[1:0]});
    chk("npc",      ID_EX_npc,      e_npc);
    chk("readdat1", ID_EX_readdat1, e_rd1);
    chk("readdat2", ID_EX_readdat2, e_rd2);
    chk("sign_ext", ID_EX_sign_ext, e_sx);
    chk("instr_2016", {27'd0, ID_EX_instr_2016}, {27'd0, e_rt});
    chk("instr_1511", {27'd0, ID_EX_instr_1511}, {27'd0, e_rd});
  endtask

  initial begin
    logic [31:0] ins;
    logic [5:0]  op;
    for (int i = 0; i < 32; i++) model_regs[i] = 32'hDEAD_BEEF;

    // Reset held two cycles with a lw on the bus.
    cyc(1, 32'h8C22_0004, 32'h4, 0, 0, 0, 0);
    cyc(1, 32'h8C22_0004, 32'h4, 1, 5'd2, 32'h1, 1);
    chk("rst_wb_const", {30'd0, ID_EX_wb_ctl}, 32'd0);
    chk("rst_rd1_const", ID_EX_readdat1, 32'd0);
    // Registers read zero after reset.
    cyc(0, 32'h0022_1820, 32'h8, 0, 0, 0, 0);
    chk("post_rst_rd2", ID_EX_readdat2, 32'd0);

    // Writeback r2 then lw r3,16(r2).
    cyc(0, 32'h0000_0000, 32'hC, 1, 5'd2, 32'h0000_00AA, 0);
    cyc(0, 32'h8C43_0010, 32'h10, 0, 0, 0, 0);
    chk("lw_rd1", ID_EX_readdat1, 32'hAA);
    chk("lw_sx", ID_EX_sign_ext, 32'h10);
    chk("lw_rt", {27'd0, ID_EX_instr_2016}, 32'd3);
    chk("lw_wb", {30'd0, ID_EX_wb_ctl}, 32'd3);
    chk("lw_m", {29'd0, ID_EX_m_ctl}, 32'd2);

    // Same-cycle bypass for add r6,r5,r5.
    cyc(0, 32'h00A5_3020, 32'h14, 1, 5'd5, 32'h1234_5678, 0);
    chk("byp_rd1", ID_EX_readdat1, 32'h1234_5678);
    chk("byp_rd2", ID_EX_readdat2, 32'h1234_5678);
    chk("byp_rd", {27'd0, ID_EX_instr_1511}, 32'd6);

    // Writes to r0 are dropped, including on the bypass path.
    cyc(0, 32'h0000_0000, 32'h18, 1, 5'd0, 32'hFFFF_FFFF, 0);
    chk("r0_bypass", ID_EX_readdat1, 32'd0);
    cyc(0, 32'h0000_0000, 32'h1C, 0, 0, 0, 0);
    chk("r0_array", ID_EX_readdat2, 32'd0);

    // beq with negative offset.
    cyc(0, 32'h1000_FFFC, 32'h0000_0040, 0, 0, 0, 0);
    chk("beq_sx", ID_EX_sign_ext, 32'hFFFF_FFFC);
    chk("beq_m", {29'd0, ID_EX_m_ctl}, 32'd4);
    chk("beq_aluop", {30'd0, ID_EX_aluop}, 32'd1);
    chk("beq_npc", ID_EX_npc, 32'h40);

    // Flushed sw and illegal opcode.
    cyc(0, 32'hAC22_0000, 32'h44, 0, 0, 0, 1);
    chk("flush_m", {29'd0, ID_EX_m_ctl}, 32'd0);
    chk("flush_rd2", ID_EX_readdat2, 32'hAA);
    chk("flush_rt", {27'd0, ID_EX_instr_2016}, 32'd2);
    cyc(0, 32'hFC22_0000, 32'h48, 0, 0, 0, 0);
    chk("illegal_alusrc", {31'd0, ID_EX_alusrc}, 32'd0);
    // Flush does not block writeback.
    cyc(0, 32'h0000_0000, 32'h4C, 1, 5'd7, 32'h0000_0055, 1);
    cyc(0, 32'h8CE8_0000, 32'h50, 0, 0, 0, 0);
    chk("flush_wb_kept", ID_EX_readdat1, 32'h55);

    // Reset mid-stream during a lw, then lw again reads the cleared register.
    cyc(1, 32'h8CE8_0000, 32'h54, 1, 5'd7, 32'h77, 0);
    chk("midrst_rd1", ID_EX_readdat1, 32'd0);
    cyc(0, 32'h8CE8_0000, 32'h58, 0, 0, 0, 0);
    chk("midrst_after", ID_EX_readdat1, 32'd0);
    chk("midrst_wb", {30'd0, ID_EX_wb_ctl}, 32'd3);

    // Randomized traffic with small register indices to provoke bypass hits.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 4))
        0: op = 6'h00;
        1: op = 6'h23;
        2: op = 6'h2B;
        3: op = 6'h04;
        default: op = 6'($urandom);
      endcase
      ins = $urandom;
      ins[31:26] = op;
      ins[25:21] = 5'($urandom_range(0, 7));
      ins[20:16] = 5'($urandom_range(0, 7));
      cyc(($urandom_range(0, 49) == 0), ins, $urandom, 1'($urandom),
          5'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 5) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
